// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ requesters, with burst atomicity.
// Optional feature macro FIFO_ARB_TAG_EN: fifo_din carries {owner_id, data} instead of data only.

module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
`ifdef FIFO_ARB_TAG_EN
    output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_din,
`else
    output logic [DATA_WIDTH-1:0]         fifo_din,
`endif
    output logic [NUM_REQ-1:0]            grant,
    output logic [ID_WIDTH-1:0]           owner_id,
    output logic                          busy
);

    localparam int                  CNT_W     = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0]    BEAT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_WIDTH-1:0] PTR_RESET = ID_WIDTH'(NUM_REQ - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [ID_WIDTH-1:0] owner_q, owner_d;
    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;

    logic                  own_valid_s;
    logic                  own_last_s;
    logic [DATA_WIDTH-1:0] own_data_s;
    logic                  pick_found_s;
    logic [ID_WIDTH-1:0]   pick_idx_s;
    logic [NUM_REQ-1:0]    pick_oh_s;
    logic                  xfer_s;
    logic                  burst_end_s;

    // Owner-side view of the request bus, selected by the one-hot grant
    always_comb begin
        own_valid_s = |(req_valid & grant_q);
        own_last_s  = |(req_last & grant_q);
        own_data_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            own_data_s = own_data_s | (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_q[i]}});
        end
    end

    // Round-robin pick: the valid requester closest above rr_ptr_q (mod NUM_REQ) wins
    always_comb begin : p_pick
        int   dist_v;
        int   best_v;
        logic take_v;
        dist_v       = 0;
        best_v       = NUM_REQ;
        take_v       = 1'b0;
        pick_idx_s   = '0;
        pick_oh_s    = '0;
        pick_found_s = |req_valid;
        for (int i = 0; i < NUM_REQ; i++) begin
            dist_v     = (i + 2 * NUM_REQ - 1 - int'(rr_ptr_q)) % NUM_REQ;
            take_v     = req_valid[i] && (dist_v < best_v);
            best_v     = take_v ? dist_v : best_v;
            pick_idx_s = take_v ? ID_WIDTH'(i) : pick_idx_s;
            pick_oh_s  = take_v ? (NUM_REQ'(1) << i) : pick_oh_s;
        end
    end

    assign xfer_s      = (state_q == ST_BURST) && own_valid_s && !fifo_full;
    assign burst_end_s = xfer_s && (own_last_s || (beat_cnt_q == BEAT_LAST));

    // Next-state: arbitrate in IDLE, count beats and release the port in BURST
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    grant_d = pick_oh_s;
                    owner_d = pick_idx_s;
                    state_d = ST_BURST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (burst_end_s) begin
                    rr_ptr_d   = owner_q;
                    beat_cnt_d = '0;
                    grant_d    = '0;
                    state_d    = ST_IDLE;
                end else if (xfer_s) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = '0;
                beat_cnt_d = '0;
            end
        endcase
    end

    // State and bookkeeping registers; reset abandons any burst in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= PTR_RESET;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign req_ready  = ((state_q == ST_BURST) && !fifo_full) ? grant_q : '0;
    assign fifo_wr_en = xfer_s;
`ifdef FIFO_ARB_TAG_EN
    assign fifo_din   = {owner_q, own_data_s};
`else
    assign fifo_din   = own_data_s;
`endif
    assign grant      = grant_q;
    assign owner_id   = owner_q;
    assign busy       = (state_q == ST_BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a packet-level round-robin model predicts the FIFO write stream.
// Also builds with FIFO_ARB_TAG_EN, where the expected word carries the source index.

module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int IW = 2;
`ifdef FIFO_ARB_TAG_EN
    localparam int DINW = DW + IW;
`else
    localparam int DINW = DW;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [DINW-1:0] fifo_din;
    logic [N-1:0]    grant;
    logic [IW-1:0]   owner_id;
    logic            busy;

    typedef struct {
        int         id;
        logic [7:0] data;
        bit         endb;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] drv_q[N][$];
    logic [8:0] mdl_q[N][$];
    int         wr_cyc_q[$];
    int         n_tests  = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         wr_total = 0;
    int         mdl_ptr  = N - 1;
    bit         after_end = 1'b0;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .grant(grant),
        .owner_id(owner_id), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic add_word(input int id, input logic [7:0] d, input bit last);
        drv_q[id].push_back({last, d});
        mdl_q[id].push_back({last, d});
    endtask

    task automatic add_rand_pkt(input int id, input int len);
        for (int j = 0; j < len; j++) add_word(id, 8'($urandom), j == len - 1);
    endtask

    // Packet-level reference: pick next non-empty requester after the pointer, take up to MB words
    task automatic model_run();
        while (1) begin
            int pick;
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (mdl_ptr + k) % N;
                if (pick < 0 && mdl_q[idx].size() > 0) pick = idx;
            end
            if (pick < 0) break;
            for (int n = 1; n <= MB; n++) begin
                logic [8:0] w;
                exp_t       e;
                w      = mdl_q[pick].pop_front();
                e.id   = pick;
                e.data = w[7:0];
                e.endb = w[8] || (n == MB);
                exp_q.push_back(e);
                if (e.endb) break;
            end
            mdl_ptr = pick;
        end
    endtask

    task automatic drive_inputs(input int bub);
        for (int i = 0; i < N; i++) begin
            if (drv_q[i].size() > 0) begin
                logic [8:0] w;
                w = drv_q[i][0];
                req_data[i*DW +: DW] = w[7:0];
                req_last[i]          = w[8];
                req_valid[i]         = !(grant[i] && ($urandom_range(99) < 32'(bub)));
            end else begin
                req_data[i*DW +: DW] = 8'($urandom);
                req_last[i]          = 1'b0;
                req_valid[i]         = 1'b0;
            end
        end
    endtask

    // full_mode: 0 never full, 1 random full, 2 five-cycle stall after the 2nd write
    task automatic run_phase(input int bub, input int full_mode, input int rst_after);
        int           budget;
        int           stall_left;
        bit           stall_done;
        int           base;
        bit           empty;
        logic [N-1:0] hs;
        logic [8:0]   tmp;
        budget = 0; stall_left = 0; stall_done = 1'b0; base = wr_total;
        wr_cyc_q.delete();
        fifo_full = 1'b0;
        drive_inputs(bub);
        while (1) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && drv_q[i].size() > 0) tmp = drv_q[i].pop_front();
            end
            if (rst_after > 0 && (wr_total - base) >= rst_after) return;
            if (full_mode == 2 && !stall_done && (wr_total - base) >= 2) begin
                stall_left = 5;
                stall_done = 1'b1;
            end
            if (full_mode == 1) fifo_full = ($urandom_range(99) < 25);
            else fifo_full = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            drive_inputs(bub);
            empty = 1'b1;
            for (int i = 0; i < N; i++) if (drv_q[i].size() > 0) empty = 1'b0;
            if (empty && !busy) break;
            budget++;
            if (budget > 4000) begin
                n_tests++;
                n_fail++;
                $display("FAIL phase_timeout: got %0d cycles expected at most 4000", budget);
                break;
            end
        end
        fifo_full = 1'b0;
        chk("leftover_expected", 32'(exp_q.size()), 32'(0));
    endtask

    // Monitor: per-cycle port rules plus scoreboard comparison of every FIFO write
    initial begin
        exp_t            e;
        logic [DINW-1:0] ed;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                chk("busy_vs_grant", 32'(busy), 32'(|grant));
                chk("req_ready", 32'(req_ready), 32'((busy && !fifo_full) ? grant : 4'b0000));
                chk("wr_en_rule", 32'(fifo_wr_en), 32'(busy && |(req_valid & grant) && !fifo_full));
                if (after_end) begin
                    chk("idle_gap", 32'({busy, grant}), 32'(0));
                    after_end = 1'b0;
                end
                if (fifo_wr_en) begin
                    wr_total++;
                    wr_cyc_q.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_write: got din %0h expected no write", fifo_din);
                    end else begin
                        e = exp_q.pop_front();
`ifdef FIFO_ARB_TAG_EN
                        ed = {IW'(e.id), e.data};
`else
                        ed = e.data;
`endif
                        chk("fifo_din", 32'(fifo_din), 32'(ed));
                        chk("owner_id", 32'(owner_id), 32'(e.id));
                        chk("grant_onehot", 32'(grant), 32'(1) << e.id);
                        after_end = e.endb;
                    end
                end
            end else begin
                after_end = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int c0;
        rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_wr_en", 32'(fifo_wr_en), 32'(0));
        chk("rst_ready", 32'(req_ready), 32'(0));
        chk("rst_owner", 32'(owner_id), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single requester: 0x11, 0x22, 0x33 on consecutive cycles, one cycle after valid
        add_word(0, 8'h11, 1'b0); add_word(0, 8'h22, 1'b0); add_word(0, 8'h33, 1'b1);
        model_run();
        c0 = cyc;
        run_phase(0, 0, 0);
        chk("p1_writes", 32'(wr_cyc_q.size()), 32'(3));
        if (wr_cyc_q.size() == 3) begin
            chk("p1_latency", 32'(wr_cyc_q[0] - c0), 32'(1));
            chk("p1_span", 32'(wr_cyc_q[2] - wr_cyc_q[0]), 32'(2));
        end
        chk("p1_owner", 32'(owner_id), 32'(0));

        // round robin, 2-word packets from everyone: one idle cycle per burst boundary
        for (int rep = 0; rep < 2; rep++) for (int i = 0; i < N; i++) add_rand_pkt(i, 2);
        model_run();
        run_phase(0, 0, 0);
        chk("p2_writes", 32'(wr_cyc_q.size()), 32'(16));
        if (wr_cyc_q.size() == 16) chk("p2_span", 32'(wr_cyc_q[15] - wr_cyc_q[0]), 32'(22));

        // burst cap: 10-word packet from requester 2 split around requester 0
        add_rand_pkt(2, 10);
        add_rand_pkt(0, 4);
        model_run();
        run_phase(0, 0, 0);
        chk("p3_writes", 32'(wr_cyc_q.size()), 32'(14));

        // full stall after beat 2; beat 3 lands on the first non-full cycle
        add_rand_pkt(1, 6);
        model_run();
        run_phase(0, 2, 0);
        chk("p4_writes", 32'(wr_cyc_q.size()), 32'(6));
        if (wr_cyc_q.size() == 6) begin
            chk("p4_stall_gap", 32'(wr_cyc_q[2] - wr_cyc_q[1]), 32'(6));
            chk("p4_resume", 32'(wr_cyc_q[3] - wr_cyc_q[2]), 32'(1));
        end

        // randomized traffic with owner bubbles and random full
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                int npk;
                npk = int'($urandom_range(2));
                for (int p = 0; p < npk; p++) add_rand_pkt(i, 1 + int'($urandom_range(6)));
            end
            model_run();
            run_phase(25, 1, 0);
        end

        // tagged word from requester 3
        add_word(3, 8'hA5, 1'b1);
        model_run();
        run_phase(0, 0, 0);
        chk("p6_writes", 32'(wr_cyc_q.size()), 32'(1));

        // reset mid-burst after 2 beats of requester 1
        add_rand_pkt(1, 4);
        model_run();
        run_phase(0, 0, 2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(grant), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_wr_en", 32'(fifo_wr_en), 32'(0));
        chk("mid_rst_ready", 32'(req_ready), 32'(0));
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            drv_q[i].delete();
            mdl_q[i].delete();
        end
        mdl_ptr = N - 1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_rst_owner", 32'(owner_id), 32'(0));
        @(posedge clk);
        #1;
        add_rand_pkt(1, 2);
        add_rand_pkt(0, 2);
        model_run();
        run_phase(0, 0, 0);
        chk("p5_writes", 32'(wr_cyc_q.size()), 32'(4));

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
